pipe_skid_stage: RTL and testbench

Parametrised, elastic pipeline-stage register. It generalises the fixed EX/MEM stall register to any payload width and adds valid/ready handshakes, a 2-entry skid buffer, flush and a hold input. Instances sit between core stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and in front of AXI-facing request paths. The full-throughput skid buffer breaks the combinational ready path between stages.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_sat_cnt.sv | 33 +++
 rtl/pipe_skid_stage.sv | 115 +++++++++++
 tb/tb_pipe_skid_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage registers: stage occupancy
// states and the EX/MEM payload layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_e;

    // EX/MEM payload; the pad field brings the packed width to 104 bits.
    typedef struct packed {
        logic [28:0] pad;
        logic        rd_wr;
        logic [4:0]  rd_addr;
        logic [31:0] alu_out;
        logic [31:0] rs2_data;
        logic        store;
        logic [2:0]  funct3;
        logic        dm_oe;
    } ex_mem_pl_t;

    localparam int EX_MEM_W = $bits(ex_mem_pl_t);

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable; sticks at all-ones.
// Latency: count visible one cycle after an enabled edge.
// Backpressure: none, counts every enabled cycle.
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with 2-entry skid buffer, hold and flush.
// Latency: 1 cycle in->out, full throughput; in_ready comes from a flop plus hold/flush.
// Backpressure: skid entry absorbs one payload when out_ready drops; optional stats via PIPE_SKID_STAT_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W  = EX_MEM_W,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy
`ifdef PIPE_SKID_STAT_EN
    ,
    output logic [31:0]       stat_stall_cnt,
    output logic [15:0]       stat_flush_cnt
`endif
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != PS_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign in_ready  = (state_q != PS_TWO) && !hold && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready && !hold && !flush;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = PS_EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            // hold is already folded into in_fire/out_fire, so nothing moves under hold
            case (state_q)
                PS_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = PS_TWO;
                    end else if (out_fire) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = PS_ONE;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_STAT_EN
    logic stall_en;
    logic flush_en;

    assign stall_en = (out_valid && !out_ready) || hold;
    assign flush_en = flush && (state_q != PS_EMPTY);

    pipe_sat_cnt #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (stall_en),
        .cnt_o (stat_stall_cnt)
    );

    pipe_sat_cnt #(.W(16)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (flush_en),
        .cnt_o (stat_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: streaming, skid, hold, flush, async reset
// and (when PIPE_SKID_STAT_EN is defined) the stall/flush counters.
module tb_pipe_skid_stage;

    localparam int                DW   = 104;
    localparam logic [DW-1:0]     RSTV = 104'hDEAD;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          hold;
    logic          flush;
    logic [1:0]    occupancy;
`ifdef PIPE_SKID_STAT_EN
    logic [31:0]   stat_stall_cnt;
    logic [15:0]   stat_flush_cnt;
`endif

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .RST_VAL(RSTV)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .hold      (hold),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef PIPE_SKID_STAT_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_flush_cnt (stat_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_out_data", out_data, RSTV);
        chk("rst_in_ready", in_ready, 1);
        #9 rst = 1'b0;
        tick();

        // streaming 0x11, 0x22, 0x33
        in_valid = 1'b1; in_data = 'h11; out_ready = 1'b1;
        #1 chk("stream_in_ready0", in_ready, 1);
        tick();
        chk("stream_d0", out_data, 'h11); chk("stream_v0", out_valid, 1); chk("stream_occ0", occupancy, 1);
        in_data = 'h22;
        #1 chk("stream_in_ready1", in_ready, 1);
        tick();
        chk("stream_d1", out_data, 'h22); chk("stream_occ1", occupancy, 1);
        in_data = 'h33;
        tick();
        chk("stream_d2", out_data, 'h33); chk("stream_occ2", occupancy, 1); chk("stream_in_ready2", in_ready, 1);
        in_valid = 1'b0;
        tick();
        chk("stream_drain_v", out_valid, 0); chk("stream_drain_occ", occupancy, 0);

        // backpressure fills the skid
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'hA;
        tick();
        chk("skid_occ1", occupancy, 1); chk("skid_d_a", out_data, 'hA);
        in_data = 'hB;
        #1 chk("skid_rdy_before", in_ready, 1);
        tick();
        chk("skid_occ2", occupancy, 2); chk("skid_rdy_full", in_ready, 0); chk("skid_head_a", out_data, 'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("skid_pop1_d", out_data, 'hB); chk("skid_pop1_occ", occupancy, 1); chk("skid_pop1_rdy", in_ready, 1);
        tick();
        chk("skid_pop2_v", out_valid, 0); chk("skid_pop2_occ", occupancy, 0);

        // hold freezes a single entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'h55;
        tick();
        chk("hold_load", out_data, 'h55);
        hold = 1'b1; in_data = 'h66; out_ready = 1'b1;
        #1 chk("hold_rdy_comb", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_d", out_data, 'h55); chk("hold_occ", occupancy, 1); chk("hold_rdy", in_ready, 0);
        end
        hold = 1'b0; in_valid = 1'b0;
        #1 chk("hold_repr_v", out_valid, 1);
        tick();
        chk("hold_consumed_v", out_valid, 0); chk("hold_consumed_occ", occupancy, 0);

        // flush beats hold, in_valid and out_ready
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'h77;
        tick();
        in_data = 'h88;
        tick();
        chk("flush_pre_occ", occupancy, 2);
        flush = 1'b1; hold = 1'b1; in_data = 'h99; out_ready = 1'b1;
        #1 chk("flush_rdy", in_ready, 0);
        tick();
        chk("flush_v", out_valid, 0); chk("flush_occ", occupancy, 0); chk("flush_d", out_data, RSTV);
        flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_no_accept_v", out_valid, 0); chk("flush_no_accept_d", out_data, RSTV);

        // asynchronous reset with two entries held
        out_ready = 1'b0; in_valid = 1'b1; in_data = 'h12;
        tick();
        in_data = 'h34;
        tick();
        in_valid = 1'b0;
        chk("arst_pre_occ", occupancy, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_v", out_valid, 0); chk("arst_occ", occupancy, 0); chk("arst_d", out_data, RSTV);
        #2 rst = 1'b0;
        tick();
        chk("arst_post_rdy", in_ready, 1); chk("arst_post_occ", occupancy, 0);

`ifdef PIPE_SKID_STAT_EN
        chk("stat_stall_rst", stat_stall_cnt, 0);
        chk("stat_flush_rst", stat_flush_cnt, 0);
        in_valid = 1'b1; in_data = 'h5A;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stat_stall5", stat_stall_cnt, 5);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        chk("stat_flush1", stat_flush_cnt, 1); chk("stat_stall_after_flush", stat_stall_cnt, 5);
        tick();
        flush = 1'b0;
        chk("stat_flush_empty", stat_flush_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
